// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder built-in self-test engine.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_RAND = 1'b1;

  // Galois right-shift feedback mask: bit (t-1) set for each tap t of a
  // primitive polynomial of degree v. Unsupported widths return 0.
  function automatic logic [31:0] lfsr_taps(input int v);
    logic [31:0] m;
    case (v)
      32'sd5:  m = 32'h0000_0014;
      32'sd6:  m = 32'h0000_0030;
      32'sd7:  m = 32'h0000_0060;
      32'sd8:  m = 32'h0000_00B8;
      32'sd9:  m = 32'h0000_0110;
      32'sd10: m = 32'h0000_0240;
      32'sd11: m = 32'h0000_0500;
      32'sd12: m = 32'h0000_0829;
      32'sd13: m = 32'h0000_100D;
      32'sd14: m = 32'h0000_2015;
      32'sd15: m = 32'h0000_6000;
      32'sd16: m = 32'h0000_D008;
      32'sd17: m = 32'h0001_2000;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/adder_bist_ripple_adder.sv
// Ripple-carry adder under test, built from full-adder cells, with an
// injectable stuck-at-0 fault on the final carry out.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             stuck_cout,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  assign cout = stuck_cout ? 1'b0 : carry[WIDTH];
endmodule

// File: rtl/adder_bist.sv
// BIST engine: generates exhaustive or LFSR vectors for a ripple adder,
// compares against a golden sum two stages later, counts mismatches and
// captures the first failing vector.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_RAND = 1000,
  parameter int SEED     = 1,
  parameter int ERR_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               fault_en,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH+1:0] vec_count,
  output logic [2*WIDTH:0]   first_fail
);

  localparam int V = 2 * WIDTH + 1;
  localparam logic [V-1:0]     SEED_V    = V'(SEED);
  localparam logic [V-1:0]     SEED_EFF  = (SEED_V == {V{1'b0}}) ? {{(V-1){1'b0}}, 1'b1} : SEED_V;
  localparam logic [V-1:0]     TAPS      = V'(lfsr_taps(V));
  localparam logic [31:0]      EXH_LAST  = (32'd1 << V) - 32'd1;
  localparam logic [31:0]      RAND_LAST = 32'(NUM_RAND) - 32'd1;
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  bist_state_t state_r, state_nx;

  logic [V-1:0]     vec_r, vec_nx_s;
  logic [31:0]      idx_r, last_idx_s;
  logic             mode_r, fault_r, drain_r;
  logic             accept_s, last_s;

  logic [WIDTH-1:0] a_s, b_s, sum_s;
  logic             cin_s, cout_s;
  logic [WIDTH:0]   gold_s;

  logic             p1_valid_r;
  logic [V-1:0]     p1_vec_r;
  logic [WIDTH:0]   p1_dut_r, p1_gold_r;
  logic             mismatch_s;

  logic             busy_nx, done_nx;
  logic             busy_r, done_r, pass_r;
  logic [ERR_W-1:0] err_count_r;
  logic [V:0]       vec_count_r;
  logic [V-1:0]     first_fail_r;

  // Operand split of the current vector and the golden reference sum.
  always_comb begin
    a_s    = vec_r[V-1 -: WIDTH];
    b_s    = vec_r[WIDTH:1];
    cin_s  = vec_r[0];
    gold_s = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
  end

  ripple_adder #(.WIDTH(WIDTH)) u_dut (
    .a          (a_s),
    .b          (b_s),
    .cin        (cin_s),
    .stuck_cout (fault_r),
    .s          (sum_s),
    .cout       (cout_s)
  );

  // Start acceptance, last-vector detection and next generator value.
  always_comb begin
    accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    last_idx_s = (mode_r == MODE_RAND) ? RAND_LAST : EXH_LAST;
    last_s     = (state_r == ST_RUN) && (idx_r == last_idx_s);
    if (mode_r == MODE_RAND) begin
      vec_nx_s = {1'b0, vec_r[V-1:1]} ^ (vec_r[0] ? TAPS : {V{1'b0}});
    end else begin
      vec_nx_s = vec_r + V'(1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic; DRAIN covers the two pipeline stages.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  if (start)   state_nx = ST_RUN;   else state_nx = ST_IDLE;
      ST_RUN:   if (last_s)  state_nx = ST_DRAIN; else state_nx = ST_RUN;
      ST_DRAIN: if (drain_r) state_nx = ST_DONE;  else state_nx = ST_DRAIN;
      ST_DONE:  if (start)   state_nx = ST_RUN;   else state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM output decode from the next state, so registered flags track the state.
  always_comb begin
    busy_nx = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
    done_nx = (state_nx == ST_DONE);
  end

  // Registered status flags; counters are already final when DONE is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      busy_r <= busy_nx;
      done_r <= done_nx;
      pass_r <= done_nx && (err_count_r == {ERR_W{1'b0}});
    end
  end

  // Vector generator, issue counter, latched run configuration and drain timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_r   <= {V{1'b0}};
      idx_r   <= 32'd0;
      mode_r  <= 1'b0;
      fault_r <= 1'b0;
      drain_r <= 1'b0;
    end else if (accept_s) begin
      vec_r   <= (mode == MODE_RAND) ? SEED_EFF : {V{1'b0}};
      idx_r   <= 32'd0;
      mode_r  <= mode;
      fault_r <= fault_en;
      drain_r <= 1'b0;
    end else if (state_r == ST_RUN) begin
      vec_r   <= vec_nx_s;
      idx_r   <= idx_r + 32'd1;
      drain_r <= 1'b0;
    end else if (state_r == ST_DRAIN) begin
      drain_r <= 1'b1;
    end else begin
      drain_r <= drain_r;
    end
  end

  // Stage 1: capture adder output, golden sum and the vector that produced them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid_r <= 1'b0;
      p1_vec_r   <= {V{1'b0}};
      p1_dut_r   <= {(WIDTH+1){1'b0}};
      p1_gold_r  <= {(WIDTH+1){1'b0}};
    end else if (accept_s) begin
      p1_valid_r <= 1'b0;
      p1_vec_r   <= {V{1'b0}};
      p1_dut_r   <= {(WIDTH+1){1'b0}};
      p1_gold_r  <= {(WIDTH+1){1'b0}};
    end else begin
      p1_valid_r <= (state_r == ST_RUN);
      p1_vec_r   <= vec_r;
      p1_dut_r   <= {cout_s, sum_s};
      p1_gold_r  <= gold_s;
    end
  end

  assign mismatch_s = (p1_dut_r != p1_gold_r);

  // Stage 2: compare, count vectors and (saturating) errors, keep first failure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_r  <= {ERR_W{1'b0}};
      vec_count_r  <= {(V+1){1'b0}};
      first_fail_r <= {V{1'b0}};
    end else if (accept_s) begin
      err_count_r  <= {ERR_W{1'b0}};
      vec_count_r  <= {(V+1){1'b0}};
      first_fail_r <= {V{1'b0}};
    end else if (p1_valid_r) begin
      vec_count_r <= vec_count_r + (V+1)'(1'b1);
      if (mismatch_s && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + ERR_W'(1'b1);
      end else begin
        err_count_r <= err_count_r;
      end
      if (mismatch_s && (err_count_r == {ERR_W{1'b0}})) begin
        first_fail_r <= p1_vec_r;
      end else begin
        first_fail_r <= first_fail_r;
      end
    end else begin
      err_count_r  <= err_count_r;
      vec_count_r  <= vec_count_r;
      first_fail_r <= first_fail_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_count_r;
  assign vec_count  = vec_count_r;
  assign first_fail = first_fail_r;

endmodule
